// File: rtl/apb_gpio_bank.sv
// Purpose : APB GPIO/probe bank with input synchroniser, sticky edge flags, change counter, one-shot pattern trigger and output drivers.
// Latency : pins_in to IN after SYNC_STAGES edges; edge flags, COUNT and trigger one edge later; OUT/OE update on the access edge.
// Backpr. : none; PREADY is tied high and every transfer completes in its access phase.
//
// Ports:
//   clk, rst_n                   clock and synchronous active-low reset
//   PSEL/PADDR/PENABLE/PWRITE    APB request; PWDATA write data, PRDATA combinational read data
//   PREADY                       constant 1
//   pins_in                      asynchronous GPIO inputs
//   pins_out, pins_oe            output value and per-bit output enable (1 = drive)
//   irq                          registered trigger hit flag
module apb_gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PSEL,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PWDATA,
    output logic [7:0]        PRDATA,
    output logic              PREADY,
    input  logic [WIDTH-1:0]  pins_in,
    output logic [WIDTH-1:0]  pins_out,
    output logic [WIDTH-1:0]  pins_oe,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_IN     = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_OUT    = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] A_OE     = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] A_RISE   = ADDR_W'(8'h03);
    localparam logic [ADDR_W-1:0] A_FALL   = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_MVAL   = ADDR_W'(8'h05);
    localparam logic [ADDR_W-1:0] A_MMASK  = ADDR_W'(8'h06);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h07);
    localparam logic [ADDR_W-1:0] A_SNAP   = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(8'h09);

    // Zero-extend a WIDTH-bit register onto the 8-bit bus.
    function automatic logic [7:0] ext(input logic [WIDTH-1:0] v);
        logic [7:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             change;

    logic [WIDTH-1:0] out_q, oe_q, rise_q, fall_q, mval_q, mmask_q, snap_q;
    logic [7:0]       count_q;
    logic             hit_q, armed_q;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             fire;

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~prev_q;
    assign fall   = ~s & prev_q;
    assign change = |(s ^ prev_q);

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign wr_data = PWDATA[WIDTH-1:0];

    // The match is evaluated on the registered ARMED/MVAL/MMASK, so an arm
    // or mask write only influences the cycle after its access edge.
    assign fire = armed_q && ((s & mmask_q) == (mval_q & mmask_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pins_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            oe_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            mval_q  <= '0;
            mmask_q <= '0;
            snap_q  <= '0;
            count_q <= '0;
            hit_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            if (wr_en && PADDR == A_OUT)   out_q   <= wr_data;
            if (wr_en && PADDR == A_OE)    oe_q    <= wr_data;
            if (wr_en && PADDR == A_MVAL)  mval_q  <= wr_data;
            if (wr_en && PADDR == A_MMASK) mmask_q <= wr_data;

            // W1C clear is applied before the new edge is ORed in, so a
            // simultaneous edge keeps the bit set.
            rise_q <= ((wr_en && PADDR == A_RISE) ? (rise_q & ~wr_data) : rise_q) | rise;
            fall_q <= ((wr_en && PADDR == A_FALL) ? (fall_q & ~wr_data) : fall_q) | fall;

            if (wr_en && PADDR == A_COUNT) begin
                count_q <= {7'd0, change};
            end else if (change && count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end

            hit_q   <= fire | (hit_q & ~(wr_en && PADDR == A_STATUS && PWDATA[0]));
            armed_q <= (armed_q & ~fire) | (wr_en && PADDR == A_STATUS && PWDATA[1]);
            if (fire) snap_q <= s;
        end
    end

    always_comb begin
        PRDATA = 8'h00;
        if (PSEL) begin
            case (PADDR)
                A_IN:     PRDATA = ext(s);
                A_OUT:    PRDATA = ext(out_q);
                A_OE:     PRDATA = ext(oe_q);
                A_RISE:   PRDATA = ext(rise_q);
                A_FALL:   PRDATA = ext(fall_q);
                A_MVAL:   PRDATA = ext(mval_q);
                A_MMASK:  PRDATA = ext(mmask_q);
                A_STATUS: PRDATA = {6'd0, armed_q, hit_q};
                A_SNAP:   PRDATA = ext(snap_q);
                A_COUNT:  PRDATA = count_q;
                default:  PRDATA = 8'h00;
            endcase
        end
    end

    assign PREADY   = 1'b1;
    assign pins_out = out_q;
    assign pins_oe  = oe_q;
    assign irq      = hit_q;

endmodule

// File: tb/tb_apb_gpio_bank.sv
module tb_apb_gpio_bank;

    localparam logic [4:0] R_IN = 5'h00, R_OUT = 5'h01, R_OE = 5'h02, R_RISE = 5'h03,
                           R_FALL = 5'h04, R_MVAL = 5'h05, R_MMASK = 5'h06,
                           R_STATUS = 5'h07, R_SNAP = 5'h08, R_COUNT = 5'h09;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       PSEL, PENABLE, PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] pins;

    logic [7:0] prdata_a, prdata_b, prdata_c;
    logic       pready_a, pready_b, pready_c;
    logic [7:0] pins_out_a, pins_oe_a, pins_out_b, pins_oe_b;
    logic [3:0] pins_out_c, pins_oe_c;
    logic       irq_a, irq_b, irq_c;

    logic [7:0] rd_a, rd_b, rd_c;
    int         errors = 0;
    int         checks = 0;

    always #50 clk = ~clk;

    // A: default build; B: deep synchroniser; C: narrow bank.
    apb_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .ADDR_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a),
        .pins_in(pins), .pins_out(pins_out_a), .pins_oe(pins_oe_a), .irq(irq_a));

    apb_gpio_bank #(.WIDTH(8), .SYNC_STAGES(4), .ADDR_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b),
        .pins_in(pins), .pins_out(pins_out_b), .pins_oe(pins_oe_b), .irq(irq_b));

    apb_gpio_bank #(.WIDTH(4), .SYNC_STAGES(2), .ADDR_W(5)) dut_c (
        .clk(clk), .rst_n(rst_n), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata_c), .PREADY(pready_c),
        .pins_in(pins[3:0]), .pins_out(pins_out_c), .pins_oe(pins_oe_c), .irq(irq_c));

    typedef struct {
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_a;
        logic [7:0] exp_c;
        logic [7:0] exp_out;
        logic [7:0] exp_oe;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Setup phase now, access phase next cycle; the register updates on the
    // second edge and the task returns just after it.
    task automatic apb_write(input logic [4:0] addr, input logic [7:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        step(1);
        PENABLE = 1'b1;
        step(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Reads are side-effect free and PRDATA is combinational, so sample
    // within the current cycle without consuming a clock edge.
    task automatic peek(input logic [4:0] addr);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1;
        rd_a = prdata_a; rd_b = prdata_b; rd_c = prdata_c;
        PSEL = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        addr     wdata   exp_a  exp_c  out    oe
        vecs[0] = '{R_OUT,    8'hA5, 8'hA5, 8'h05, 8'hA5, 8'h00};
        vecs[1] = '{R_OE,     8'h0F, 8'h0F, 8'h0F, 8'hA5, 8'h0F};
        vecs[2] = '{R_MVAL,   8'h3C, 8'h3C, 8'h0C, 8'hA5, 8'h0F};
        vecs[3] = '{R_MMASK,  8'hF0, 8'hF0, 8'h00, 8'hA5, 8'h0F};
        vecs[4] = '{5'h0A,    8'hFF, 8'h00, 8'h00, 8'hA5, 8'h0F};
        vecs[5] = '{5'h1F,    8'h55, 8'h00, 8'h00, 8'hA5, 8'h0F};
        vecs[6] = '{R_SNAP,   8'h77, 8'h00, 8'h00, 8'hA5, 8'h0F};
        vecs[7] = '{R_IN,     8'hFF, 8'h00, 8'h00, 8'hA5, 8'h0F};
        vecs[8] = '{R_STATUS, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h0F};

        rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 5'h01; PWDATA = 8'h00; pins = 8'h00;
        step(3);

        // Reset state of every output on all three builds.
        check("rst_prdata_a", prdata_a, 8'h00);
        check("rst_prdata_b", prdata_b, 8'h00);
        check("rst_prdata_c", prdata_c, 8'h00);
        check("rst_pready", {5'd0, pready_a, pready_b, pready_c}, 8'h07);
        check("rst_pins_out_a", pins_out_a, 8'h00);
        check("rst_pins_oe_a", pins_oe_a, 8'h00);
        check("rst_pins_b", pins_out_b | pins_oe_b, 8'h00);
        check("rst_pins_c", {pins_out_c, pins_oe_c}, 8'h00);
        check("rst_irq", {5'd0, irq_a, irq_b, irq_c}, 8'h00);

        rst_n = 1'b1;
        step(1);
        peek(R_STATUS); check("rst_status_a", rd_a, 8'h00);
        peek(R_COUNT);  check("rst_count_a", rd_a, 8'h00);

        // Register write/readback table.
        for (int i = 0; i < 9; i++) begin
            apb_write(vecs[i].addr, vecs[i].wdata);
            peek(vecs[i].addr);
            check($sformatf("vec%0d_rd_a", i), rd_a, vecs[i].exp_a);
            check($sformatf("vec%0d_rd_c", i), rd_c, vecs[i].exp_c);
            check($sformatf("vec%0d_out_a", i), pins_out_a, vecs[i].exp_out);
            check($sformatf("vec%0d_oe_a", i), pins_oe_a, vecs[i].exp_oe);
        end

        PADDR = R_OUT; PSEL = 1'b0;
        #1 check("prdata_idle", prdata_a, 8'h00);

        // Input synchroniser latency and edge capture.
        pins = 8'h81;
        step(1); peek(R_IN);   check("in_a_1edge", rd_a, 8'h00);
        step(1); peek(R_IN);   check("in_a_2edge", rd_a, 8'h81);
                               check("in_c_2edge", rd_c, 8'h01);
                               check("in_b_2edge", rd_b, 8'h00);
        step(1); peek(R_RISE); check("rise_a", rd_a, 8'h81);
                               check("rise_c", rd_c, 8'h01);
                 peek(R_COUNT); check("count_a_1", rd_a, 8'h01);
                 peek(R_IN);   check("in_b_3edge", rd_b, 8'h00);
        step(1); peek(R_IN);   check("in_b_4edge", rd_b, 8'h81);
        step(1); peek(R_RISE); check("rise_b", rd_b, 8'h81);
                 peek(R_COUNT); check("count_b_1", rd_b, 8'h01);
        apb_write(R_RISE, 8'h01);
        peek(R_RISE); check("rise_w1c_a", rd_a, 8'h80);
                      check("rise_w1c_b", rd_b, 8'h80);
        peek(R_FALL); check("fall_a_none", rd_a, 8'h00);

        // Pattern trigger (MVAL 0x3C, MMASK 0xF0 on A; MMASK 0 on C).
        apb_write(R_STATUS, 8'h02);
        peek(R_STATUS); check("armed_a", rd_a, 8'h02);
                        check("armed_c", rd_c, 8'h02);
        step(1);
        peek(R_STATUS); check("c_mask0_fire", rd_c, 8'h01);
        peek(R_SNAP);   check("c_mask0_snap", rd_c, 8'h01);
        peek(R_STATUS); check("a_still_armed", rd_a, 8'h02);
        pins = 8'h20;
        step(4);
        peek(R_STATUS); check("nomatch_status", rd_a, 8'h02);
        check("nomatch_irq", {7'd0, irq_a}, 8'h00);
        pins = 8'h35;
        step(2); check("match_cycle_irq", {7'd0, irq_a}, 8'h00);
        step(1); check("hit_irq", {7'd0, irq_a}, 8'h01);
        peek(R_STATUS); check("hit_status", rd_a, 8'h01);
        peek(R_SNAP);   check("hit_snap", rd_a, 8'h35);
        pins = 8'h3F;
        step(4);
        peek(R_SNAP);   check("oneshot_snap", rd_a, 8'h35);
        apb_write(R_STATUS, 8'h03);
        peek(R_STATUS); check("clear_and_arm", rd_a, 8'h02);
        step(1);
        peek(R_STATUS); check("rearm_fire", rd_a, 8'h01);
        peek(R_SNAP);   check("rearm_snap", rd_a, 8'h3F);

        // HIT W1C landing on the same edge as a fire.
        pins = 8'h00;
        step(4);
        apb_write(R_STATUS, 8'h02);
        peek(R_STATUS); check("arm_keep_hit", rd_a, 8'h03);
        pins = 8'h30;
        step(1);
        apb_write(R_STATUS, 8'h01);
        peek(R_STATUS); check("hit_w1c_vs_fire", rd_a, 8'h01);
        peek(R_SNAP);   check("hit_w1c_snap", rd_a, 8'h30);

        // Same-cycle W1C/edge and COUNT clear/change.
        pins = 8'h00;
        step(4);
        apb_write(R_RISE, 8'hFF);
        apb_write(R_FALL, 8'hFF);
        apb_write(R_COUNT, 8'h00);
        peek(R_RISE);  check("rise_cleared", rd_a, 8'h00);
        peek(R_FALL);  check("fall_cleared", rd_a, 8'h00);
        peek(R_COUNT); check("count_cleared", rd_a, 8'h00);
        pins = 8'h01;
        step(1);
        apb_write(R_RISE, 8'h01);
        peek(R_RISE);  check("rise_w1c_vs_edge", rd_a, 8'h01);
        apb_write(R_RISE, 8'h01);
        peek(R_RISE);  check("rise_w1c_plain", rd_a, 8'h00);
        peek(R_COUNT); check("count_after_rise", rd_a, 8'h01);
        pins = 8'h00;
        step(1);
        apb_write(R_COUNT, 8'h00);
        peek(R_COUNT); check("count_clr_vs_change", rd_a, 8'h01);
        peek(R_FALL);  check("fall_bit0", rd_a, 8'h01);

        // Saturation.
        apb_write(R_COUNT, 8'h00);
        for (int i = 0; i < 300; i++) begin
            pins[0] = ~pins[0];
            step(1);
        end
        step(5);
        peek(R_COUNT); check("count_sat_a", rd_a, 8'hFF);
                       check("count_sat_b", rd_b, 8'hFF);
                       check("count_sat_c", rd_c, 8'hFF);

        // Narrow bank upper bits.
        pins = 8'hF5;
        step(4);
        peek(R_IN);   check("in_a_f5", rd_a, 8'hF5);
                      check("in_c_narrow", rd_c, 8'h05);
        peek(R_RISE); check("rise_a_f5", rd_a, 8'hF5);
                      check("rise_c_narrow", rd_c, 8'h05);
        peek(R_OUT);  check("out_c_narrow", rd_c, 8'h05);

        // Reset in the middle of operation.
        apb_write(R_OUT, 8'hFF);
        apb_write(R_STATUS, 8'h03);
        peek(R_STATUS); check("pre_rst_armed", rd_a, 8'h02);
        check("pre_rst_out", pins_out_a, 8'hFF);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_out", pins_out_a, 8'h00);
        check("mid_rst_oe", pins_oe_a, 8'h00);
        check("mid_rst_irq", {7'd0, irq_a}, 8'h00);
        peek(R_STATUS); check("mid_rst_status", rd_a, 8'h00);
        peek(R_COUNT);  check("mid_rst_count", rd_a, 8'h00);
        peek(R_RISE);   check("mid_rst_rise", rd_a, 8'h00);
        rst_n = 1'b1;
        step(2);
        peek(R_IN);    check("boot_in", rd_a, 8'hF5);
        peek(R_RISE);  check("boot_rise_early", rd_a, 8'h00);
        step(1);
        peek(R_RISE);  check("boot_rise", rd_a, 8'hF5);
        peek(R_COUNT); check("boot_count", rd_a, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_gpio_bank.md
# apb_gpio_bank

Parametrised APB-attached GPIO and probe peripheral that sits behind the I2C-to-APB adapter in place of the single-register debugger. It synchronises WIDTH input pins through a configurable-depth chain, records sticky rising and falling edges, and counts input change events. It provides a one-shot masked pattern trigger that captures a snapshot and raises irq, and drives WIDTH output pins with per-bit output enables.

## Interface
Parameters:
- WIDTH, 8, number of GPIO channels; legal 1..8, bus bits [7:WIDTH] read 0 and are ignored on write
- SYNC_STAGES, 2, input synchroniser depth; legal 2..4
- ADDR_W, 5, APB address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- PSEL  in  1  APB select
- PADDR  in  ADDR_W  APB byte address
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write
- PWDATA  in  8  write data
- PRDATA  out  8  read data
- PREADY  out  1  tied 1, zero wait states
- pins_in  in  WIDTH  asynchronous pin inputs
- pins_out  out  WIDTH  output register OUT
- pins_oe  out  WIDTH  output enable register OE, 1 = drive
- irq  out  1  equals STATUS.HIT

## Operation
- Write strobe: PSEL & PENABLE & PWRITE. Reads have no side effects. PRDATA is combinational from PADDR while PSEL = 1 and 0 otherwise. Unmapped addresses read 0, and writes to them are ignored.
- Synchroniser: SYNC_STAGES flops, all reset 0. s = last stage. prev <= s every cycle, reset 0. rise = s & ~prev. fall = ~s & prev. change = |(s ^ prev).
- Register map:
  - 0x00 IN (RO): s.
  - 0x01 OUT (RW), reset 0.
  - 0x02 OE (RW), reset 0.
  - 0x03 RISE (RW1C): bit set by rise. Writing 1 clears the bit.
  - 0x04 FALL (RW1C): same as RISE, driven by fall.
  - 0x05 MVAL (RW), reset 0.
  - 0x06 MMASK (RW), reset 0.
  - 0x07 STATUS: bit0 HIT, W1C. bit1 ARMED; writing 1 arms, writing 0 has no effect. Reset 0.
  - 0x08 SNAP (RO), reset 0.
  - 0x09 COUNT (RO-clear): 8-bit count of cycles with change = 1, saturating at 255. Any write clears it.
- Trigger:
  - While ARMED = 1 and (s & MMASK) == (MVAL & MMASK), on the next edge: SNAP <= s, HIT <= 1, ARMED <= 0.
  - MMASK = 0 fires on the first armed cycle.
- Simultaneous events:
  - W1C write and a new edge on the same bit in the same cycle: bit ends set.
  - COUNT clear and change in the same cycle: COUNT = 1.
  - HIT W1C and trigger fire in the same cycle: HIT ends 1.
  - Arm write: ARMED is visible the next cycle, and the match is evaluated from that cycle on. Writing STATUS = 0x03 clears HIT and arms.
  - Writes to MVAL or MMASK take effect for the evaluation in the following cycle.
- Inputs high at reset release produce RISE bits and one COUNT increment SYNC_STAGES+1 cycles later. This is intended behaviour, and software clears them at boot.

## Timing
- Reset values, all outputs: PRDATA 0, PREADY 1, pins_out 0, pins_oe 0, irq 0. All internal registers reset to 0.
- pins_in change to IN readable: SYNC_STAGES clk edges.
- RISE, FALL, COUNT and trigger update one edge after IN changes. Total latency from the pin is SYNC_STAGES+1.
- irq asserts the edge after the match cycle and is registered.
- APB write to OUT or OE: pins change on the edge that completes the access phase.
- Read-after-write in back-to-back transfers returns the new value.
- Reset mid-operation clears everything, including ARMED, within one edge. An APB transfer in flight is dropped.

## Test plan
- Reset with pins_in = 0x00. Write OUT = 0xA5, then OE = 0x0F. Required: pins_out = 0xA5 and pins_oe = 0x0F after the respective access edges. Read-back matches.
- pins_in 0x00 -> 0x81. Required: IN = 0x81 after 2 edges (SYNC_STAGES=2), RISE = 0x81, COUNT = 1. Write RISE = 0x01, then read 0x80. Repeat with SYNC_STAGES=4 and check a 4-edge latency.
- MVAL = 0x3C, MMASK = 0xF0, STATUS = 0x02. Drive pins 0x20, then 0x35. Required: no HIT on 0x20. On 0x35: HIT = 1, irq = 1, SNAP = 0x35, ARMED = 0. A later 0x3F does not change SNAP.
- Same-cycle W1C of RISE bit0 with a new rising edge on bit0: bit remains 1. Same-cycle COUNT clear with a change: COUNT = 1.
- Toggle pin0 every cycle for 300 cycles. Required: COUNT = 255, no wrap. With WIDTH = 4: reads of IN, RISE and OUT have bits [7:4] = 0.
- Assert rst_n = 0 while ARMED = 1 and OUT = 0xFF. Required: next edge gives pins_out = 0, ARMED = 0, irq = 0, COUNT = 0.
